// File: rtl/histo_th_calc.sv
// Histogram threshold calculator: one pass over the bins builds the cumulative count and records
// the first bin that reaches each k*N/2**P_QNT_BIT target. Optional macro HISTO_TH_CLR_EN clears bins as they are read.
module histo_th_calc #(
  parameter int P_DEPTH_BIT = 8,
  parameter int P_SIZE_BIT  = 10,
  parameter int P_QNT_BIT   = 3,
  parameter int P_TH_NUM    = 7
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic [P_SIZE_BIT:0]             pix_num_i,
  output logic                            histo_sram_rd_o,
  output logic [P_DEPTH_BIT-1:0]          histo_sram_a_o,
  input  logic [P_SIZE_BIT-1:0]           histo_sram_d_i,
`ifdef HISTO_TH_CLR_EN
  output logic                            histo_sram_we_o,
  output logic [P_DEPTH_BIT-1:0]          histo_sram_wa_o,
`endif
  output logic [P_TH_NUM*P_DEPTH_BIT-1:0] th_o,
  output logic                            th_vld_o,
  output logic                            busy_o
);

  localparam int L_CUM_W = P_DEPTH_BIT + P_SIZE_BIT;
  localparam int L_TGT_W = P_SIZE_BIT + 1 + P_QNT_BIT;
  localparam logic [P_DEPTH_BIT-1:0] L_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_rd;
  logic [P_DEPTH_BIT-1:0]  r_addr;
  logic                    r_dvld;
  logic [P_DEPTH_BIT-1:0]  r_bin;
  logic [L_CUM_W-1:0]      r_cum;
  logic [L_CUM_W-1:0]      w_cum_nxt;
  logic [L_CUM_W-1:0]      r_tgt [P_TH_NUM];
  logic [P_DEPTH_BIT-1:0]  r_th  [P_TH_NUM];
  logic [P_TH_NUM-1:0]     r_filled;
  logic                    r_th_vld;
  logic                    w_start;
  logic                    w_to_done;

  assign w_start   = (r_state == S_IDLE) && start_i;
  // DRAIN waits until the last returned bin has been accumulated
  assign w_to_done = (r_state == S_DRAIN) && !r_dvld;
  assign w_cum_nxt = r_cum + L_CUM_W'(histo_sram_d_i);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_READ;
      S_READ:  if (r_addr == L_LAST) w_next = S_DRAIN;
      S_DRAIN: if (!r_dvld) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rd     <= 1'b0;
      r_addr   <= '0;
      r_dvld   <= 1'b0;
      r_bin    <= '0;
      r_cum    <= '0;
      r_filled <= '0;
      r_th_vld <= 1'b0;
      for (int k = 0; k < P_TH_NUM; k++) begin
        r_tgt[k] <= '0;
        r_th[k]  <= '0;
      end
    end else begin
      r_state <= w_next;
      r_dvld  <= r_rd;
      r_bin   <= r_addr;

      if (r_state == S_READ) begin
        if (r_addr == L_LAST) r_rd <= 1'b0;
        else                  r_addr <= r_addr + 1'b1;
      end

      // every unfilled target is checked against the running total including this bin
      if (r_dvld) begin
        r_cum <= w_cum_nxt;
        for (int k = 0; k < P_TH_NUM; k++) begin
          if (!r_filled[k] && (w_cum_nxt >= r_tgt[k])) begin
            r_filled[k] <= 1'b1;
            r_th[k]     <= r_bin;
          end
        end
      end

      if (w_to_done) begin
        r_th_vld <= 1'b1;
        for (int k = 0; k < P_TH_NUM; k++)
          if (!r_filled[k]) r_th[k] <= L_LAST;
      end

      if (w_start) begin
        r_rd     <= 1'b1;
        r_addr   <= '0;
        r_cum    <= '0;
        r_filled <= '0;
        r_th_vld <= 1'b0;
        for (int k = 0; k < P_TH_NUM; k++)
          r_tgt[k] <= L_CUM_W'((L_TGT_W'(k + 1) * L_TGT_W'(pix_num_i)) >> P_QNT_BIT);
      end
    end
  end

  always_comb begin
    th_o = '0;
    for (int k = 0; k < P_TH_NUM; k++)
      th_o[k*P_DEPTH_BIT +: P_DEPTH_BIT] = r_th[k];
  end

  assign histo_sram_rd_o = r_rd;
  assign histo_sram_a_o  = r_addr;
  assign th_vld_o        = r_th_vld;
  assign busy_o          = (r_state == S_READ) || (r_state == S_DRAIN);

`ifdef HISTO_TH_CLR_EN
  // write enable is gated by reset so it falls without waiting for an edge
  assign histo_sram_we_o = r_dvld & rst_n;
  assign histo_sram_wa_o = r_bin;
`endif

endmodule
